// File: rtl/mpt_pkg.sv
// Shared types and constants for the PLB port arbiter.
package mpt_pkg;

    typedef enum logic {
        PLB_OWNER_LOOKUP = 1'b0,
        PLB_OWNER_REFILL = 1'b1
    } plb_arb_owner_e;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        LOCK_LOOKUP = 2'd1,
        LOCK_REFILL = 2'd2
    } plb_arb_state_e;

    localparam int unsigned PLB_ARB_DEFAULT_OUTSTANDING = 4;

endpackage

// File: rtl/plb_owner_tracker.sv
// In-order FIFO of 1-bit owner IDs for outstanding PLB transactions.
module plb_owner_tracker
    import mpt_pkg::*;
#(
    parameter int unsigned DEPTH = PLB_ARB_DEFAULT_OUTSTANDING
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           push_i,
    input  plb_arb_owner_e push_owner_i,
    input  logic           pop_i,
    output plb_arb_owner_e head_owner_o,
    output logic           full_o,
    output logic           empty_o,
    output logic           empty_next_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [DEPTH-1:0] mem_q, mem_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_owner_i;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_owner_o = plb_arb_owner_e'(mem_q[rd_ptr_q]);
    assign empty_next_o = (count_d == '0);

endmodule

// File: rtl/plb_port_arbiter.sv
// Shares the PLB MEM port between lookup and refill with in-order response routing.
// Optional macro PLB_ARB_PERF_CNT_EN adds grant/stall performance counters.
module plb_port_arbiter
    import mpt_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = 64,
    parameter int unsigned ADDR_WIDTH      = 64,
    parameter int unsigned MAX_OUTSTANDING = PLB_ARB_DEFAULT_OUTSTANDING,
    parameter int unsigned STARVE_LIMIT    = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,

    input  logic                    lookup_slave_mem_req,
    output logic                    lookup_slave_mem_gnt,
    output logic                    lookup_slave_mem_valid,
    input  logic [ADDR_WIDTH-1:0]   lookup_slave_mem_addr,
    input  logic [DATA_WIDTH-1:0]   lookup_slave_mem_wdata,
    input  logic                    lookup_slave_mem_we,
    input  logic [DATA_WIDTH/8-1:0] lookup_slave_mem_be,
    output logic [DATA_WIDTH-1:0]   lookup_slave_mem_rdata,
    output logic                    lookup_slave_mem_error,

    input  logic                    refill_slave_mem_req,
    output logic                    refill_slave_mem_gnt,
    output logic                    refill_slave_mem_valid,
    input  logic [ADDR_WIDTH-1:0]   refill_slave_mem_addr,
    input  logic [DATA_WIDTH-1:0]   refill_slave_mem_wdata,
    input  logic                    refill_slave_mem_we,
    input  logic [DATA_WIDTH/8-1:0] refill_slave_mem_be,
    output logic [DATA_WIDTH-1:0]   refill_slave_mem_rdata,
    output logic                    refill_slave_mem_error,

    output logic                    plb_master_mem_req,
    output logic [ADDR_WIDTH-1:0]   plb_master_mem_addr,
    output logic [DATA_WIDTH-1:0]   plb_master_mem_wdata,
    output logic                    plb_master_mem_we,
    output logic [DATA_WIDTH/8-1:0] plb_master_mem_be,
    input  logic                    plb_master_mem_gnt,
    input  logic                    plb_master_mem_valid,
    input  logic [DATA_WIDTH-1:0]   plb_master_mem_rdata,
    input  logic                    plb_master_mem_error,

    input  logic                    drain_req_i,
    output logic                    drain_ack_o,
    output logic                    protocol_error_o
`ifdef PLB_ARB_PERF_CNT_EN
    ,
    output logic [31:0]             perf_lookup_grants_o,
    output logic [31:0]             perf_refill_grants_o,
    output logic [31:0]             perf_lookup_stall_o
`endif
);

    // state       | meaning
    // IDLE        | no winner held; pick refill first unless lookup is starved
    // LOCK_LOOKUP | lookup won but is not yet granted; keep it selected
    // LOCK_REFILL | refill won but is not yet granted; keep it selected

    localparam int unsigned SC_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [SC_W-1:0] SC_MAX = SC_W'(STARVE_LIMIT);
    localparam logic [SC_W-1:0] SC_ONE = SC_W'(1);

    plb_arb_state_e state_q, state_d;
    plb_arb_owner_e winner, head_owner;
    logic           winner_valid, lock_violation, starved;
    logic           issue_en, grant_fire, resp_fire, sel_refill;
    logic           trk_full, trk_empty, trk_empty_next;
    logic [SC_W-1:0] starve_cnt_q, starve_cnt_d;
    logic           proto_err_q, proto_err_d;
    logic           drain_ack_q;

    assign starved = (starve_cnt_q == SC_MAX);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = IDLE;
        if (!lock_violation && winner_valid && !grant_fire) begin
            state_d = (winner == PLB_OWNER_REFILL) ? LOCK_REFILL : LOCK_LOOKUP;
        end
    end

    always_comb begin
        winner_valid   = 1'b0;
        winner         = PLB_OWNER_LOOKUP;
        lock_violation = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (refill_slave_mem_req && !(lookup_slave_mem_req && starved)) begin
                    winner_valid = 1'b1;
                    winner       = PLB_OWNER_REFILL;
                end else if (lookup_slave_mem_req) begin
                    winner_valid = 1'b1;
                end
            end
            LOCK_LOOKUP: begin
                winner_valid   = lookup_slave_mem_req;
                lock_violation = !lookup_slave_mem_req;
            end
            LOCK_REFILL: begin
                winner_valid   = refill_slave_mem_req;
                winner         = PLB_OWNER_REFILL;
                lock_violation = !refill_slave_mem_req;
            end
            default: ;
        endcase
    end

    // A response in the same cycle frees a slot, so a full tracker may still issue.
    assign issue_en   = !drain_req_i && (!trk_full || plb_master_mem_valid);
    assign sel_refill = (winner == PLB_OWNER_REFILL);

    assign plb_master_mem_req   = winner_valid && issue_en;
    assign plb_master_mem_addr  = sel_refill ? refill_slave_mem_addr  : lookup_slave_mem_addr;
    assign plb_master_mem_wdata = sel_refill ? refill_slave_mem_wdata : lookup_slave_mem_wdata;
    assign plb_master_mem_we    = sel_refill ? refill_slave_mem_we    : lookup_slave_mem_we;
    assign plb_master_mem_be    = sel_refill ? refill_slave_mem_be    : lookup_slave_mem_be;

    assign grant_fire           = plb_master_mem_req && plb_master_mem_gnt;
    assign lookup_slave_mem_gnt = grant_fire && !sel_refill;
    assign refill_slave_mem_gnt = grant_fire && sel_refill;

    plb_owner_tracker #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_tracker (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .push_i       (grant_fire),
        .push_owner_i (winner),
        .pop_i        (plb_master_mem_valid),
        .head_owner_o (head_owner),
        .full_o       (trk_full),
        .empty_o      (trk_empty),
        .empty_next_o (trk_empty_next)
    );

    assign resp_fire              = plb_master_mem_valid && !trk_empty;
    assign lookup_slave_mem_valid = resp_fire && (head_owner == PLB_OWNER_LOOKUP);
    assign refill_slave_mem_valid = resp_fire && (head_owner == PLB_OWNER_REFILL);
    assign lookup_slave_mem_rdata = lookup_slave_mem_valid ? plb_master_mem_rdata : '0;
    assign refill_slave_mem_rdata = refill_slave_mem_valid ? plb_master_mem_rdata : '0;
    assign lookup_slave_mem_error = lookup_slave_mem_valid && plb_master_mem_error;
    assign refill_slave_mem_error = refill_slave_mem_valid && plb_master_mem_error;

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (lookup_slave_mem_req && refill_slave_mem_gnt) begin
            starve_cnt_d = starved ? starve_cnt_q : starve_cnt_q + SC_ONE;
        end else if (!lookup_slave_mem_req || lookup_slave_mem_gnt) begin
            starve_cnt_d = '0;
        end
    end

    assign proto_err_d = proto_err_q || lock_violation || (plb_master_mem_valid && trk_empty);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            starve_cnt_q <= '0;
            proto_err_q  <= 1'b0;
            drain_ack_q  <= 1'b1;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            proto_err_q  <= proto_err_d;
            drain_ack_q  <= trk_empty_next;
        end
    end

    assign drain_ack_o      = drain_ack_q;
    assign protocol_error_o = proto_err_q;

`ifdef PLB_ARB_PERF_CNT_EN
    logic [31:0] perf_lg_q, perf_rg_q, perf_ls_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_lg_q <= '0;
            perf_rg_q <= '0;
            perf_ls_q <= '0;
        end else begin
            perf_lg_q <= perf_lg_q + 32'(lookup_slave_mem_gnt);
            perf_rg_q <= perf_rg_q + 32'(refill_slave_mem_gnt);
            perf_ls_q <= perf_ls_q + 32'(lookup_slave_mem_req && !lookup_slave_mem_gnt);
        end
    end

    assign perf_lookup_grants_o = perf_lg_q;
    assign perf_refill_grants_o = perf_rg_q;
    assign perf_lookup_stall_o  = perf_ls_q;
`endif

endmodule

// File: tb/tb_plb_port_arbiter.sv
// Randomized scoreboard bench for plb_port_arbiter against a behavioural arbitration model.
module tb_plb_port_arbiter;

    localparam int DW   = 64;
    localparam int AW   = 64;
    localparam int BW   = DW / 8;
    localparam int MAXO = 4;
    localparam int SLIM = 8;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;

    logic          lookup_slave_mem_req = 1'b0, lookup_slave_mem_gnt, lookup_slave_mem_valid;
    logic [AW-1:0] lookup_slave_mem_addr = '0;
    logic [DW-1:0] lookup_slave_mem_wdata = '0, lookup_slave_mem_rdata;
    logic          lookup_slave_mem_we = 1'b0, lookup_slave_mem_error;
    logic [BW-1:0] lookup_slave_mem_be = '0;

    logic          refill_slave_mem_req = 1'b0, refill_slave_mem_gnt, refill_slave_mem_valid;
    logic [AW-1:0] refill_slave_mem_addr = '0;
    logic [DW-1:0] refill_slave_mem_wdata = '0, refill_slave_mem_rdata;
    logic          refill_slave_mem_we = 1'b0, refill_slave_mem_error;
    logic [BW-1:0] refill_slave_mem_be = '0;

    logic          plb_master_mem_req, plb_master_mem_we;
    logic [AW-1:0] plb_master_mem_addr;
    logic [DW-1:0] plb_master_mem_wdata;
    logic [BW-1:0] plb_master_mem_be;
    logic          plb_master_mem_gnt = 1'b0, plb_master_mem_valid = 1'b0, plb_master_mem_error = 1'b0;
    logic [DW-1:0] plb_master_mem_rdata = '0;

    logic drain_req_i = 1'b0, drain_ack_o, protocol_error_o;

`ifdef PLB_ARB_PERF_CNT_EN
    logic [31:0] perf_lookup_grants_o, perf_refill_grants_o, perf_lookup_stall_o;
`endif

    always #5 clk_i = ~clk_i;

    plb_port_arbiter #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_OUTSTANDING(MAXO), .STARVE_LIMIT(SLIM)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .lookup_slave_mem_req(lookup_slave_mem_req), .lookup_slave_mem_gnt(lookup_slave_mem_gnt),
        .lookup_slave_mem_valid(lookup_slave_mem_valid), .lookup_slave_mem_addr(lookup_slave_mem_addr),
        .lookup_slave_mem_wdata(lookup_slave_mem_wdata), .lookup_slave_mem_we(lookup_slave_mem_we),
        .lookup_slave_mem_be(lookup_slave_mem_be), .lookup_slave_mem_rdata(lookup_slave_mem_rdata),
        .lookup_slave_mem_error(lookup_slave_mem_error),
        .refill_slave_mem_req(refill_slave_mem_req), .refill_slave_mem_gnt(refill_slave_mem_gnt),
        .refill_slave_mem_valid(refill_slave_mem_valid), .refill_slave_mem_addr(refill_slave_mem_addr),
        .refill_slave_mem_wdata(refill_slave_mem_wdata), .refill_slave_mem_we(refill_slave_mem_we),
        .refill_slave_mem_be(refill_slave_mem_be), .refill_slave_mem_rdata(refill_slave_mem_rdata),
        .refill_slave_mem_error(refill_slave_mem_error),
        .plb_master_mem_req(plb_master_mem_req), .plb_master_mem_addr(plb_master_mem_addr),
        .plb_master_mem_wdata(plb_master_mem_wdata), .plb_master_mem_we(plb_master_mem_we),
        .plb_master_mem_be(plb_master_mem_be), .plb_master_mem_gnt(plb_master_mem_gnt),
        .plb_master_mem_valid(plb_master_mem_valid), .plb_master_mem_rdata(plb_master_mem_rdata),
        .plb_master_mem_error(plb_master_mem_error),
        .drain_req_i(drain_req_i), .drain_ack_o(drain_ack_o), .protocol_error_o(protocol_error_o)
`ifdef PLB_ARB_PERF_CNT_EN
        , .perf_lookup_grants_o(perf_lookup_grants_o), .perf_refill_grants_o(perf_refill_grants_o),
        .perf_lookup_stall_o(perf_lookup_stall_o)
`endif
    );

    typedef struct packed {
        logic          owner;
        logic [DW-1:0] rdata;
        logic          err;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW:0]   rsp_q[$];
    int            checks = 0;
    int            failures = 0;

    // stimulus knobs (percent probabilities)
    int  p_lreq = 0, p_rreq = 0, p_gnt = 0, p_val = 0;
    bit  drain = 1'b0, spurious = 1'b0;
    bit  l_pend = 1'b0, r_pend = 1'b0;

    // reference model: lock holder 0=none 1=lookup 2=refill
    int  m_lock = 0, m_starve = 0, m_out = 0;
    bit  m_ack = 1'b1, m_perr = 1'b0;
    int  m_lg = 0, m_rg = 0, m_ls = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic drive_inputs();
        if (!l_pend && int'($urandom_range(99)) < p_lreq) begin
            l_pend                 = 1'b1;
            lookup_slave_mem_addr  = {$urandom, $urandom};
            lookup_slave_mem_wdata = {$urandom, $urandom};
            lookup_slave_mem_we    = 1'($urandom_range(1));
            lookup_slave_mem_be    = BW'($urandom);
        end
        if (!r_pend && int'($urandom_range(99)) < p_rreq) begin
            r_pend                 = 1'b1;
            refill_slave_mem_addr  = {$urandom, $urandom};
            refill_slave_mem_wdata = {$urandom, $urandom};
            refill_slave_mem_we    = 1'($urandom_range(1));
            refill_slave_mem_be    = BW'($urandom);
        end
        lookup_slave_mem_req = l_pend;
        refill_slave_mem_req = r_pend;
        drain_req_i          = drain;
        plb_master_mem_gnt   = int'($urandom_range(99)) < p_gnt;
        if (spurious) begin
            plb_master_mem_valid = 1'b1;
            plb_master_mem_rdata = {$urandom, $urandom};
            plb_master_mem_error = 1'($urandom_range(1));
        end else if (rsp_q.size() > 0 && int'($urandom_range(99)) < p_val) begin
            plb_master_mem_valid = 1'b1;
            {plb_master_mem_error, plb_master_mem_rdata} = rsp_q.pop_front();
        end else begin
            plb_master_mem_valid = 1'b0;
            plb_master_mem_rdata = {$urandom, $urandom};
            plb_master_mem_error = 1'($urandom_range(1));
        end
    endtask

    task automatic model_eval();
        int            w;
        bit            lreq, issue, fire, pop;
        logic [DW-1:0] rd;
        logic          er;
        lreq = l_pend;
        if (m_lock != 0) w = m_lock;
        else if (r_pend && !(l_pend && m_starve >= SLIM)) w = 2;
        else if (l_pend) w = 1;
        else w = 0;
        issue = !drain && (m_out < MAXO || plb_master_mem_valid);
        fire  = (w != 0) && issue && plb_master_mem_gnt;

        chk("plb_req", 64'(plb_master_mem_req), 64'((w != 0) && issue));
        if ((w != 0) && issue) begin
            chk("plb_addr", plb_master_mem_addr, (w == 2) ? refill_slave_mem_addr : lookup_slave_mem_addr);
            chk("plb_wdata", plb_master_mem_wdata, (w == 2) ? refill_slave_mem_wdata : lookup_slave_mem_wdata);
            chk("plb_we_be", 64'({plb_master_mem_we, plb_master_mem_be}),
                64'((w == 2) ? {refill_slave_mem_we, refill_slave_mem_be} : {lookup_slave_mem_we, lookup_slave_mem_be}));
        end
        chk("lookup_gnt", 64'(lookup_slave_mem_gnt), 64'(fire && w == 1));
        chk("refill_gnt", 64'(refill_slave_mem_gnt), 64'(fire && w == 2));
        chk("drain_ack", 64'(drain_ack_o), 64'(m_ack));
        chk("protocol_error", 64'(protocol_error_o), 64'(m_perr));

        pop = plb_master_mem_valid && m_out > 0;
        if (plb_master_mem_valid && m_out == 0) m_perr = 1'b1;
        if (fire) begin
            rd = {$urandom, $urandom};
            er = 1'($urandom_range(1));
            exp_q.push_back('{owner: (w == 2), rdata: rd, err: er});
            rsp_q.push_back({er, rd});
            if (w == 1) begin l_pend = 1'b0; m_lg++; end
            else begin r_pend = 1'b0; m_rg++; end
        end
        if (lreq && !(fire && w == 1)) m_ls++;
        if (lreq && fire && w == 2) m_starve = (m_starve < SLIM) ? m_starve + 1 : SLIM;
        else if (!lreq || (fire && w == 1)) m_starve = 0;
        m_lock = ((w != 0) && !fire) ? w : 0;
        m_out  = m_out + int'(fire) - int'(pop);
        m_ack  = (m_out == 0);
    endtask

    task automatic run_cycles(input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk_i); #1;
            drive_inputs();
            @(negedge clk_i);
            model_eval();
        end
    endtask

    task automatic do_reset();
        @(posedge clk_i); #1;
        rst_ni = 1'b0;
        l_pend = 1'b0; r_pend = 1'b0; drain = 1'b0; spurious = 1'b0;
        lookup_slave_mem_req = 1'b0; refill_slave_mem_req = 1'b0;
        plb_master_mem_gnt = 1'b0; plb_master_mem_valid = 1'b0; drain_req_i = 1'b0;
        exp_q.delete(); rsp_q.delete();
        m_lock = 0; m_starve = 0; m_out = 0; m_ack = 1'b1; m_perr = 1'b0;
        m_lg = 0; m_rg = 0; m_ls = 0;
        @(negedge clk_i);
        chk("rst_drain_ack", 64'(drain_ack_o), 64'd1);
        chk("rst_protocol_error", 64'(protocol_error_o), 64'd0);
        chk("rst_req_gnt", 64'({plb_master_mem_req, lookup_slave_mem_gnt, refill_slave_mem_gnt}), 64'd0);
        chk("rst_valid", 64'({lookup_slave_mem_valid, refill_slave_mem_valid}), 64'd0);
        chk("rst_rdata", lookup_slave_mem_rdata | refill_slave_mem_rdata, 64'd0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
    endtask

    // response monitor: pops the scoreboard whenever a slave port presents a response
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (rst_ni) begin
                if (lookup_slave_mem_valid || refill_slave_mem_valid) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL rsp_unexpected lookup_valid=%0b refill_valid=%0b expected none at %0t",
                                 lookup_slave_mem_valid, refill_slave_mem_valid, $time);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rsp_route", 64'({lookup_slave_mem_valid, refill_slave_mem_valid}),
                            e.owner ? 64'd1 : 64'd2);
                        chk("rsp_rdata", e.owner ? refill_slave_mem_rdata : lookup_slave_mem_rdata, e.rdata);
                        chk("rsp_error", 64'(e.owner ? refill_slave_mem_error : lookup_slave_mem_error), 64'(e.err));
                        chk("rsp_other_rdata", e.owner ? lookup_slave_mem_rdata : refill_slave_mem_rdata, 64'd0);
                    end
                end else begin
                    chk("idle_rdata", lookup_slave_mem_rdata | refill_slave_mem_rdata, 64'd0);
                    if (plb_master_mem_valid)
                        chk("rsp_dropped", 64'(lookup_slave_mem_valid | refill_slave_mem_valid), 64'(!spurious));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        do_reset();
        // lookup alone, immediate grants
        p_lreq = 100; p_rreq = 0; p_gnt = 100; p_val = 100;
        run_cycles(20);
        // both saturating: starvation limit forces periodic lookup wins
        p_rreq = 100;
        run_cycles(40);
        // PLB withholds grants, locks persist
        p_lreq = 60; p_rreq = 60; p_gnt = 25; p_val = 60;
        run_cycles(200);
        // fill the tracker with no responses, then release
        p_lreq = 100; p_rreq = 100; p_gnt = 100; p_val = 0;
        run_cycles(10);
        p_val = 100;
        run_cycles(10);
        for (int k = 0; k < 20; k++) begin
            drain  = ($urandom_range(3) == 0);
            p_lreq = int'($urandom_range(100));
            p_rreq = int'($urandom_range(100));
            p_gnt  = int'($urandom_range(20, 100));
            p_val  = int'($urandom_range(20, 100));
            run_cycles(30);
        end
        // drain with outstanding transactions
        drain = 1'b0; p_lreq = 100; p_rreq = 100; p_gnt = 100; p_val = 0;
        run_cycles(3);
        drain = 1'b1; p_val = 40;
        n = 0;
        while (m_out != 0 && n < 200) begin
            run_cycles(1);
            n++;
        end
        if (n >= 200) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout outstanding=%0d required=0", m_out);
        end
        run_cycles(3);
        // spurious response with empty tracker
        spurious = 1'b1;
        run_cycles(1);
        spurious = 1'b0;
        run_cycles(4);
`ifdef PLB_ARB_PERF_CNT_EN
        chk("perf_lookup_grants", 64'(perf_lookup_grants_o), 64'(m_lg));
        chk("perf_refill_grants", 64'(perf_refill_grants_o), 64'(m_rg));
        chk("perf_lookup_stall", 64'(perf_lookup_stall_o), 64'(m_ls));
`endif
        // reset in the middle of traffic, then resume
        drain = 1'b0; p_lreq = 100; p_rreq = 100; p_gnt = 100; p_val = 0;
        run_cycles(3);
        do_reset();
        p_lreq = 50; p_rreq = 50; p_gnt = 60; p_val = 60;
        run_cycles(100);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
